// File: rtl/frame_launch_ctrl.sv
// -----------------------------------------------------------------------------
// frame_launch_ctrl
//
// Captures exactly one complete video frame (SOP..EOP) from a free-running
// upstream Avalon-ST stream on a start request and forwards it unmodified to
// the accelerator input. It then waits for the accelerator completion pulse,
// or a timeout, and reports status. If start_flag is held high, the block
// re-arms after every frame (repeat mode).
//
// Ports
//   clock_sink_clk    : clock
//   reset_sink_reset  : asynchronous, active-high reset
//   start_flag        : start level from CSR (pulse = one frame, held = repeat)
//   led_1_flag[2:0]   : per-LED enable mask
//   asi_*             : upstream stream (valid/ready/sop/eop/data)
//   aso_*             : accelerator-side stream (valid/ready/sop/eop/data)
//   acc_done          : single-cycle completion pulse from the accelerator
//   busy              : high in ARM, PASS and WAIT_DONE
//   frame_done        : one-cycle pulse per completed frame (also on timeout)
//   frame_count[15:0] : completed frames, wrapping
//   pixel_count       : beats in the last forwarded frame
//   timeout_err       : sticky, cleared by the next start request
//   led[2:0]          : registered status LEDs
// -----------------------------------------------------------------------------
module frame_launch_ctrl #(
  parameter int DATA_W         = 24,
  parameter int CNT_W          = 24,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int REPEAT_HOLD    = 8
) (
  input  logic              clock_sink_clk,
  input  logic              reset_sink_reset,
  input  logic              start_flag,
  input  logic [2:0]        led_1_flag,
  input  logic              asi_valid,
  output logic              asi_ready,
  input  logic              asi_sop,
  input  logic              asi_eop,
  input  logic [DATA_W-1:0] asi_data,
  output logic              aso_valid,
  input  logic              aso_ready,
  output logic              aso_sop,
  output logic              aso_eop,
  output logic [DATA_W-1:0] aso_data,
  input  logic              acc_done,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic [CNT_W-1:0]  pixel_count,
  output logic              timeout_err,
  output logic [2:0]        led
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]      HOLD_THR = 5'(REPEAT_HOLD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PASS = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [3:0] sat_inc_hold(input logic [3:0] v);
    return (&v) ? v : v + 4'd1;
  endfunction

  state_t            r_state;
  state_t            w_next_state;
  logic              r_start_q;
  logic              r_pending;
  logic [3:0]        r_hold_cnt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_frame_done;
  logic [15:0]       r_frame_count;
  logic [CNT_W-1:0]  r_pixel_count;
  logic              r_timeout_err;
  logic [2:0]        r_led;

  logic w_rise;
  logic w_repeat;
  logic w_asi_ready;
  logic w_aso_valid;
  logic w_xfer;
  logic w_consume;
  logic w_complete;
  logic w_timeout;
  logic w_arm_clear;

  assign w_rise   = start_flag & ~r_start_q;
  assign w_repeat = ({1'b0, r_hold_cnt} >= HOLD_THR);

  // Start request detection
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      r_start_q  <= 1'b0;
      r_hold_cnt <= 4'd0;
      r_pending  <= 1'b0;
    end else begin
      r_start_q  <= start_flag;
      r_hold_cnt <= start_flag ? sat_inc_hold(r_hold_cnt) : 4'd0;
      // A fresh request arriving in the same cycle one is consumed stays pending.
      if (w_rise)
        r_pending <= 1'b1;
      else if (w_consume)
        r_pending <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  // FSM next state and stream steering
  always_comb begin
    w_next_state = r_state;
    w_asi_ready  = 1'b1;
    w_aso_valid  = 1'b0;
    w_consume    = 1'b0;
    w_complete   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_consume    = 1'b1;
          w_next_state = S_ARM;
        end
      end
      S_ARM: begin
        // Only an SOP beat opens the frame; anything else is drained.
        if (asi_valid && asi_sop) begin
          w_aso_valid = 1'b1;
          w_asi_ready = aso_ready;
          if (aso_ready)
            w_next_state = asi_eop ? S_WAIT : S_PASS;
        end
      end
      S_PASS: begin
        w_aso_valid = asi_valid;
        w_asi_ready = aso_ready;
        if (asi_valid && aso_ready && asi_eop)
          w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (acc_done || (r_to_cnt == TO_LAST)) begin
          w_complete = 1'b1;
          w_timeout  = ~acc_done;
          if (w_repeat || r_pending) begin
            w_consume    = r_pending;
            w_next_state = S_ARM;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_xfer      = w_aso_valid & aso_ready;
  assign w_arm_clear = (r_state == S_IDLE) & r_pending;

  // Beat counting and status registers
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset) begin
      r_beat_cnt    <= '0;
      r_pixel_count <= '0;
      r_to_cnt      <= '0;
      r_frame_done  <= 1'b0;
      r_frame_count <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_xfer) begin
        if (r_state == S_ARM) begin
          r_beat_cnt <= CNT_W'(1);
          if (asi_eop)
            r_pixel_count <= CNT_W'(1);
        end else begin
          r_beat_cnt <= sat_inc_cnt(r_beat_cnt);
          if (asi_eop)
            r_pixel_count <= sat_inc_cnt(r_beat_cnt);
        end
      end

      r_to_cnt <= (r_state == S_WAIT) ? r_to_cnt + TO_W'(1) : '0;

      r_frame_done <= w_complete;
      if (w_complete)
        r_frame_count <= r_frame_count + 16'd1;

      // A timeout in the same cycle as a new request still latches the error.
      if (w_timeout)
        r_timeout_err <= 1'b1;
      else if (w_rise || w_arm_clear)
        r_timeout_err <= 1'b0;
    end
  end

  // LED register, one cycle behind its sources
  always_ff @(posedge clock_sink_clk or posedge reset_sink_reset) begin
    if (reset_sink_reset)
      r_led <= 3'b000;
    else
      r_led <= {led_1_flag[2] & r_timeout_err,
                led_1_flag[1] & r_frame_count[0],
                led_1_flag[0] & busy};
  end

  assign asi_ready   = w_asi_ready;
  assign aso_valid   = w_aso_valid;
  assign aso_sop     = asi_sop;
  assign aso_eop     = asi_eop;
  assign aso_data    = asi_data;
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign pixel_count = r_pixel_count;
  assign timeout_err = r_timeout_err;
  assign led         = r_led;

endmodule

// File: doc/frame_launch_ctrl.md
# frame_launch_ctrl

Downstream consumer of the CSR start/LED flags. On a start request it captures exactly one complete video frame (SOP..EOP) from the free-running upstream Avalon-ST video stream and forwards it unmodified to the AI accelerator input. It then waits for the accelerator's completion pulse, or for a timeout, and reports status. When the start flag is held high (repeat mode), it re-arms automatically after each frame.

## Interface
Parameters:
- DATA_W, 24, pixel data width (RGB888)
- CNT_W, 24, beat/pixel counter width
- TIMEOUT_CYCLES, 50000000, max cycles in WAIT_DONE before abort
- REPEAT_HOLD, 8, consecutive high cycles of start_flag that qualify as repeat mode

Ports:
- clock_sink_clk  in  1  clock
- reset_sink_reset  in  1  asynchronous, active-high reset
- start_flag  in  1  start request level from CSR block; a short pulse means a single frame, a held-high level means repeat
- led_1_flag  in  3  per-LED enable mask from CSR block
- asi_valid / asi_ready / asi_sop / asi_eop  in/out/in/in  1 each  upstream video stream handshake and framing
- asi_data  in  DATA_W  upstream pixel
- aso_valid / aso_ready / aso_sop / aso_eop  out/in/out/out  1 each  accelerator-side stream
- aso_data  out  DATA_W  forwarded pixel
- acc_done  in  1  single-cycle completion pulse from accelerator
- busy  out  1  high in ARM, PASS and WAIT_DONE
- frame_done  out  1  one-cycle pulse when a frame completes, including on timeout
- frame_count  out  16  completed frames; wraps 0xFFFF->0
- pixel_count  out  CNT_W  beats in last forwarded frame
- timeout_err  out  1  sticky; cleared on next start rising edge
- led  out  3  registered status LEDs

## Operation
- Start detect: start_flag is registered. A rising edge sets `pending`. A saturating 4-bit `hold_cnt` counts consecutive high cycles and clears when start_flag is low. `repeat_mode` = (hold_cnt >= REPEAT_HOLD).
- FSM states: IDLE, ARM, PASS, WAIT_DONE.
- IDLE: asi_ready=1 (drop), aso_valid=0. If pending: clear pending, clear timeout_err, go to ARM.
- ARM:
  - Non-SOP beats are dropped (asi_ready=1, aso_valid=0).
  - When asi_valid&asi_sop, pass through combinationally: aso_valid=asi_valid, asi_ready=aso_ready, data/sop/eop wired straight.
  - On SOP transfer, beat counter := 1, then go to PASS. If that beat also has eop, go directly to WAIT_DONE with pixel_count=1.
- PASS:
  - Full passthrough; each transfer increments the beat counter. Mid-frame SOP beats are forwarded unchanged.
  - On the eop transfer: pixel_count := counter+1 (the final beat included), then go to WAIT_DONE.
  - The beat counter saturates at all-ones.
- WAIT_DONE:
  - asi_ready=1 (drop), aso_valid=0. The timeout counter increments each cycle.
  - acc_done: frame_done pulse, frame_count++.
  - Timeout counter reaching TIMEOUT_CYCLES-1: timeout_err:=1, frame_done pulse, frame_count++.
  - Next state after either event: ARM if repeat_mode or pending (pending is cleared), else IDLE.
- acc_done in any state other than WAIT_DONE is ignored.
- A start edge during ARM/PASS/WAIT_DONE only sets pending; the current frame is not aborted.
- LEDs (registered):
  - led[0] = led_1_flag[0] & busy
  - led[1] = led_1_flag[1] & frame_count[0]
  - led[2] = led_1_flag[2] & timeout_err
- Reset (asynchronous, any state): state=IDLE, pending=0, hold_cnt=0, counters=0, busy=0, frame_done=0, frame_count=0, pixel_count=0, timeout_err=0, led=0. aso_valid=0 immediately, because it is decoded from state. A frame cut by reset is not completed downstream.

## Timing
- Data path latency is 0 cycles in ARM(SOP)/PASS. The combinational paths are aso_ready->asi_ready and asi_*->aso_*.
- Start to ARM:
  - The rising edge is registered at cycle N+1, pending is set at N+1, and the FSM enters ARM at N+2.
  - busy rises at N+2.
- frame_done asserts in the cycle after acc_done is sampled. FSM is in IDLE/ARM in the same cycle.
- Status outputs are registered. led lags its sources by 1 cycle.
- Back-to-back repeat: after WAIT_DONE->ARM, the first frame accepted is the next SOP. Any frame already in progress upstream is discarded.

## Test plan
- Single-frame start: 4-cycle start pulse; stream 3 junk beats, then a 16-beat frame, then acc_done 5 cycles after EOP. Expect junk dropped, exactly 16 beats on aso with sop on beat 0 and eop on beat 15, pixel_count=16, one frame_done, frame_count=1, then IDLE.
- Backpressure: aso_ready toggles 1/0 every cycle during PASS. Expect asi_ready to mirror aso_ready, no beat lost or duplicated, data order preserved, pixel_count=16.
- Repeat mode: start_flag held high; three 8-beat frames with acc_done after each. Expect frame_count=3, busy continuously high, no IDLE visits. Then drop start_flag; after the 4th completion expect IDLE.
- Timeout: TIMEOUT_CYCLES=100, no acc_done. Expect timeout_err=1 and frame_done exactly 100 cycles after WAIT_DONE entry. With led_1_flag=3'b111 expect led[2]=1. Next start edge clears timeout_err.
- Single-beat frame (sop&eop together) in ARM: expect direct WAIT_DONE, pixel_count=1.
- Reset mid-PASS after 5 beats: expect aso_valid=0 at once, all outputs at reset values. After release, a new start captures a full fresh frame.
